fir_mac_scheduler: RTL and testbench
====================================

# fir_mac_scheduler

Sequencer and two-channel arbiter for the shared FIR multiply-accumulate datapath. It grants one requesting channel at a time, writes the new sample into that channel's circular delay line, and walks sample and coefficient addresses across all FIR_SIZE taps. It drives accumulator clear/enable, aligned to the datapath pipeline latency, and pulses out_valid when the accumulated result is final. It sits between the input stream handshake and the memories, multiplier, adder and accumulator of the FIR datapath.

## Interface
- FIR_SIZE, 64, number of taps; must be a power of 2.
- ADDR_W, $clog2(FIR_SIZE), address width for delay line and coefficient memory.
- MAC_LAT, 2, cycles from rd_addr/coef_addr presentation to product at accumulator input (memory read 1 + multiplier register 1); must be ≥1.
- clkk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  2  per-channel sample request.
- in_ready  out  2  per-channel grant; a sample is accepted when in_valid[i] & in_ready[i] are both high at a clock edge.
- ch_sel  out  1  channel currently owning the datapath (delay-line bank select).
- wr_en  out  1  write accepted sample into delay line.
- wr_addr  out  ADDR_W  delay-line write address.
- rd_addr  out  ADDR_W  delay-line read address.
- coef_addr  out  ADDR_W  coefficient read address.
- acc_clr  out  1  zero accumulator.
- acc_en  out  1  add product into accumulator.
- out_valid  out  1  one-cycle pulse; accumulator holds the final result.
- out_ch  out  1  channel of the current out_valid.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, MAC, DRAIN, DONE (plus FLUSH, see Configuration).
- IDLE:
  - If exactly one in_valid is high, grant that channel.
  - If both are high, grant the channel not served last (round-robin, last_ch).
  - in_ready[grant] = 1 and the other bit = 0. in_ready is combinational from in_valid and state; in_valid must not depend on in_ready.
  - On acceptance, latch ch_sel and go to LOAD.
- LOAD (1 cycle): wr_en=1, wr_addr=head[ch_sel], acc_clr=1. Then go to MAC with k=0.
- MAC (FIR_SIZE cycles, k=0..FIR_SIZE-1):
  - rd_addr = (head[ch_sel] − k) mod FIR_SIZE; natural ADDR_W wrap, so the newest sample pairs with coef 0.
  - coef_addr = k.
  - A tap-valid bit enters a MAC_LAT-deep shift register; acc_en is its output.
  - After k=FIR_SIZE−1, go to DRAIN.
- DRAIN (MAC_LAT cycles): addresses are don't-care, the shift register empties, then go to DONE.
- DONE (1 cycle): out_valid=1, out_ch=ch_sel, head[ch_sel] += 1 (wraps FIR_SIZE−1→0), last_ch=ch_sel. Then go to IDLE.
- Separate head pointer per channel; the non-selected channel's head never changes.
- Reset (any state, including mid-MAC):
  - State goes to IDLE; heads=0; last_ch=1 (channel 0 wins the first tie); shift register cleared.
  - Outputs: in_ready=0 while rst_n low; ch_sel, wr_en, wr_addr, rd_addr, coef_addr, acc_clr, acc_en, out_valid, out_ch and busy are all 0.
  - An in-flight result is discarded with no out_valid.

## Timing
- Accept edge E0; LOAD after E0; MAC after E1..E(FIR_SIZE); DRAIN for MAC_LAT cycles; out_valid high in the cycle after edge E(1+FIR_SIZE+MAC_LAT). Defaults: after E67, with state back in IDLE at E68.
- acc_en is high for exactly FIR_SIZE consecutive cycles, after E(1+MAC_LAT) through E(FIR_SIZE+MAC_LAT). It is never high in the same cycle as acc_clr.
- Minimum spacing between accepts: FIR_SIZE+MAC_LAT+3 cycles (68+... = 69 at defaults). in_ready is 0 whenever busy=1.
- A request arriving while busy waits. The requester must hold in_valid until accepted.

## Configuration
- FIR_FLUSH_EN defined:
  - Adds input flush (1 bit) and flush_ch (1 bit).
  - flush high in IDLE takes priority over in_valid and enters FLUSH.
  - FLUSH lasts FIR_SIZE cycles: ch_sel=flush_ch, wr_en=1, wr_addr=0..FIR_SIZE−1, and the datapath writes zero.
  - Adds output wr_zero=1 during FLUSH.
  - At exit, head[flush_ch]=0 and the state returns to IDLE; busy=1 and out_valid=0 throughout.
  - flush outside IDLE is ignored.
- FIR_FLUSH_EN undefined: the flush, flush_ch and wr_zero ports and the FLUSH state do not exist; history clears only via the delay-line contents' natural aging.

## Test plan
- Reset then single request: in_valid=01 → accepted at the first edge after reset release; LOAD wr_addr=0; MAC rd_addr sequence 0,63,62,…,1 with coef_addr 0..63; out_valid after 67 edges, out_ch=0.
- Successive ch0 samples: the second sample writes wr_addr=1 and its first MAC rd_addr=1; after 64 samples head wraps to 0.
- Simultaneous requests, in_valid=11 held: grants alternate 0,1,0,1; the ch1 head is unaffected by ch0 traffic.
- acc_en alignment: count acc_en-high cycles per transaction = 64; the first one comes 2 cycles after MAC start; acc_clr occurs only in LOAD.
- Reset asserted mid-MAC (k=30): next edge sets IDLE, all outputs 0, heads 0, no out_valid; a subsequent request behaves as after power-up.
- FIR_FLUSH_EN: flush=1, flush_ch=1 in IDLE with in_valid=01 → FLUSH wins, 64 zero writes to addresses 0..63, then the ch0 request is accepted.

Source files
------------

// File: rtl/fir_mac_scheduler.sv
// Two-channel arbiter and tap sequencer for the shared FIR multiply-accumulate datapath.
// Define FIR_FLUSH_EN to add the delay-line zero-flush state and its flush_i/flush_ch_i/wr_zero_o ports.
module fir_mac_scheduler #(
  parameter int FIR_SIZE = 64,
  parameter int ADDR_W   = $clog2(FIR_SIZE),
  parameter int MAC_LAT  = 2
) (
  input  logic              clkk,
  input  logic              rst_n,
  input  logic [1:0]        in_valid_i,
  output logic [1:0]        in_ready_o,
  output logic              ch_sel_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] coef_addr_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic              out_valid_o,
  output logic              out_ch_o,
  output logic              busy_o
`ifdef FIR_FLUSH_EN
  ,
  input  logic              flush_i,
  input  logic              flush_ch_i,
  output logic              wr_zero_o
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] MAC   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] FLUSH = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(FIR_SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(MAC_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ch_sel_q, ch_sel_d;
  logic              last_ch_q, last_ch_d;
  logic [ADDR_W-1:0] head_q [2];
  logic [ADDR_W-1:0] head_d [2];
  logic [MAC_LAT-1:0] tap_sr_q, tap_sr_d;
  logic [MAC_LAT:0]   tap_sr_ext;

  logic gnt_ch;
  logic flush_req;
  logic flush_ch;

`ifdef FIR_FLUSH_EN
  assign flush_req = flush_i;
  assign flush_ch  = flush_ch_i;
  assign wr_zero_o = (state_q == FLUSH);
`else
  assign flush_req = 1'b0;
  assign flush_ch  = 1'b0;
`endif

  // On a tie the channel not served last wins.
  assign gnt_ch = (in_valid_i == 2'b11) ? ~last_ch_q : in_valid_i[1];

  always_comb begin
    in_ready_o = 2'b00;
    if (rst_n && (state_q == IDLE) && !flush_req && (|in_valid_i))
      in_ready_o = gnt_ch ? 2'b10 : 2'b01;
  end

  assign tap_sr_ext = {tap_sr_q, (state_q == MAC)};
  assign tap_sr_d   = tap_sr_ext[MAC_LAT-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_sel_d  = ch_sel_q;
    last_ch_d = last_ch_q;
    head_d    = head_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d  = FLUSH;
          ch_sel_d = flush_ch;
          cnt_d    = '0;
        end else if (|in_ready_o) begin
          state_d  = LOAD;
          ch_sel_d = gnt_ch;
        end
      end
      LOAD: begin
        state_d = MAC;
        cnt_d   = '0;
      end
      MAC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_TAP) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_DRAIN) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d          = IDLE;
        head_d[ch_sel_q] = head_q[ch_sel_q] + 1'b1;
        last_ch_d        = ch_sel_q;
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_TAP) begin
          state_d          = IDLE;
          cnt_d            = '0;
          head_d[ch_sel_q] = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ch_sel_q  <= 1'b0;
      last_ch_q <= 1'b1;
      head_q[0] <= '0;
      head_q[1] <= '0;
      tap_sr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_sel_q  <= ch_sel_d;
      last_ch_q <= last_ch_d;
      head_q[0] <= head_d[0];
      head_q[1] <= head_d[1];
      tap_sr_q  <= tap_sr_d;
    end
  end

  always_comb begin
    wr_en_o     = 1'b0;
    wr_addr_o   = '0;
    rd_addr_o   = '0;
    coef_addr_o = '0;
    acc_clr_o   = 1'b0;
    out_valid_o = 1'b0;
    out_ch_o    = 1'b0;
    case (state_q)
      LOAD: begin
        wr_en_o   = 1'b1;
        wr_addr_o = head_q[ch_sel_q];
        acc_clr_o = 1'b1;
      end
      MAC: begin
        rd_addr_o   = head_q[ch_sel_q] - cnt_q;
        coef_addr_o = cnt_q;
      end
      DONE: begin
        out_valid_o = 1'b1;
        out_ch_o    = ch_sel_q;
      end
      FLUSH: begin
        wr_en_o   = 1'b1;
        wr_addr_o = cnt_q;
      end
      default: ;
    endcase
  end

  assign ch_sel_o = ch_sel_q;
  assign acc_en_o = tap_sr_q[MAC_LAT-1];
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler at default parameters (64 taps, latency 2).
module tb_fir_mac_scheduler;

  logic       clkk = 1'b0;
  logic       rst_n;
  logic [1:0] in_valid_i;
  logic [1:0] in_ready_o;
  logic       ch_sel_o, wr_en_o, acc_clr_o, acc_en_o, out_valid_o, out_ch_o, busy_o;
  logic [5:0] wr_addr_o, rd_addr_o, coef_addr_o;

  int checks = 0;
  int fails  = 0;
  logic [5:0] h [2];

  fir_mac_scheduler dut (
    .clkk        (clkk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .ch_sel_o    (ch_sel_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .rd_addr_o   (rd_addr_o),
    .coef_addr_o (coef_addr_o),
    .acc_clr_o   (acc_clr_o),
    .acc_en_o    (acc_en_o),
    .out_valid_o (out_valid_o),
    .out_ch_o    (out_ch_o),
    .busy_o      (busy_o)
  );

  always #5 clkk = ~clkk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE: present the request, check the grant, step into LOAD.
  task automatic accept(input logic [1:0] v, input logic [1:0] exp_gnt);
    in_valid_i = v;
    #1;
    chk("grant", 32'(in_ready_o), 32'(exp_gnt));
    @(negedge clkk);
  endtask

  // Called at the LOAD-cycle negedge; walks the whole transaction and ends in IDLE.
  task automatic txn(input logic ch);
    int en_cnt = 0, first_en = -1, ov_cnt = 0, clr_cnt = 0, bad = 0;
    logic [5:0] hd, ea;
    hd = h[ch];
    chk("load_wr_en", 32'(wr_en_o), 32'd1);
    chk("load_wr_addr", 32'(wr_addr_o), 32'(hd));
    chk("load_ch_sel", 32'(ch_sel_o), 32'(ch));
    chk("load_acc_clr", 32'(acc_clr_o), 32'd1);
    for (int i = 0; i <= 67; i++) begin
      if (i > 0) @(negedge clkk);
      if (acc_en_o) begin
        en_cnt++;
        if (first_en < 0) first_en = i;
      end
      if (acc_en_o && acc_clr_o) bad++;
      if (acc_clr_o) clr_cnt++;
      if (out_valid_o) ov_cnt++;
      if (in_ready_o !== 2'b00 || busy_o !== 1'b1) bad++;
      if (i >= 1 && i <= 64) begin
        ea = hd - 6'(i - 1);
        if (rd_addr_o !== ea || coef_addr_o !== 6'(i - 1)) bad++;
      end
    end
    chk("done_out_valid", 32'(out_valid_o), 32'd1);
    chk("done_out_ch", 32'(out_ch_o), 32'(ch));
    chk("acc_en_count", 32'(en_cnt), 32'd64);
    chk("acc_en_first", 32'(first_en), 32'd3);
    chk("acc_clr_count", 32'(clr_cnt), 32'd1);
    chk("out_valid_count", 32'(ov_cnt), 32'd1);
    chk("seq_errors", 32'(bad), 32'd0);
    @(negedge clkk);
    chk("idle_busy", 32'(busy_o), 32'd0);
    h[ch] = h[ch] + 6'd1;
  endtask

  initial begin
    logic [5:0] ea;
    int ov;
    h[0] = '0;
    h[1] = '0;
    rst_n = 1'b0;
    in_valid_i = 2'b01;
    repeat (3) @(negedge clkk);
    #1;
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_outputs", 32'({ch_sel_o, wr_en_o, wr_addr_o, rd_addr_o, coef_addr_o, acc_clr_o,
                           acc_en_o, out_valid_o, out_ch_o, busy_o}), 32'd0);

    rst_n = 1'b1;
    accept(2'b01, 2'b01);
    in_valid_i = 2'b00;
    txn(1'b0);
    accept(2'b01, 2'b01);
    in_valid_i = 2'b00;
    txn(1'b0);

    // Tie held high: last served was ch0, so ch1 first, then alternate.
    accept(2'b11, 2'b10); txn(1'b1);
    accept(2'b11, 2'b01); txn(1'b0);
    accept(2'b11, 2'b10); txn(1'b1);
    accept(2'b11, 2'b01); txn(1'b0);
    in_valid_i = 2'b00;

    while (h[0] != 6'd0) begin
      accept(2'b01, 2'b01);
      in_valid_i = 2'b00;
      txn(1'b0);
    end
    chk("ch1_head_kept", 32'(h[1]), 32'd2);
    accept(2'b01, 2'b01);
    in_valid_i = 2'b00;
    txn(1'b0);

    // Reset in the middle of the tap walk.
    accept(2'b01, 2'b01);
    in_valid_i = 2'b00;
    repeat (31) @(negedge clkk);
    ea = h[0] - 6'd30;
    chk("mid_rd_addr", 32'(rd_addr_o), 32'(ea));
    chk("mid_coef_addr", 32'(coef_addr_o), 32'd30);
    rst_n = 1'b0;
    @(negedge clkk);
    chk("midrst_outputs", 32'({ch_sel_o, wr_en_o, wr_addr_o, rd_addr_o, coef_addr_o, acc_clr_o,
                              acc_en_o, out_valid_o, out_ch_o, busy_o, in_ready_o}), 32'd0);
    ov = 0;
    repeat (40) begin
      @(negedge clkk);
      if (out_valid_o) ov++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clkk);
      if (out_valid_o) ov++;
    end
    chk("midrst_no_out_valid", 32'(ov), 32'd0);
    h[0] = '0;
    h[1] = '0;
    accept(2'b10, 2'b10);
    in_valid_i = 2'b00;
    txn(1'b1);
    accept(2'b01, 2'b01);
    in_valid_i = 2'b00;
    txn(1'b0);

    // Fresh reset: ch0 must win the first tie.
    rst_n = 1'b0;
    @(negedge clkk);
    rst_n = 1'b1;
    h[0] = '0;
    h[1] = '0;
    accept(2'b11, 2'b01);
    in_valid_i = 2'b00;
    txn(1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
